bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter AWIDTH, default 32, address width of all ports.
REQ-002 Parameter MAXOUT, default 4, max accepted-but-unacked strobes on out port (1..15).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 mN_adr_i (N=0,1)  input  AWIDTH  pipelined Wishbone master N address.
REQ-006 mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  master N cycle, strobe, write enable.
REQ-007 mN_sel_i  input  4  master N byte selects.
REQ-008 mN_dat_i  input  32  master N write data.
REQ-009 mN_dat_o  output  32  read data to master N.
REQ-010 mN_ack_o, mN_stall_o  output  1 each  ack and stall to master N.
REQ-011 out_adr_o, out_cyc_o, out_stb_o, out_we_o, out_sel_o, out_dat_o  output  AWIDTH/1/1/1/4/32  shared slave-side bus (toward cache).
REQ-012 out_dat_i, out_ack_i, out_stall_i  input  32/1/1  slave read data, ack, stall.
REQ-013 grant_o  output  2  one-hot current grant (bit N = master N); 00 when idle.
REQ-014 pending_o  output  4  outstanding-strobe count.
REQ-015 spurious_o  output  1  sticky flag: ack received with no outstanding strobe.

Function
REQ-016 FSM states IDLE, GNT0, GNT1; state register is sole source of grant_o.
REQ-017 IDLE: if exactly one mN_cyc_i high, next state GNTN; if both high, grant master not granted last (register last_gnt); neither -> stay IDLE.
REQ-018 Grant latency: cyc seen in cycle T -> grant_o and out_cyc_o asserted from cycle T+1; no strobe forwarded in cycle T.
REQ-019 GNTN: held while mN_cyc_i=1; when mN_cyc_i=0, next state IDLE, last_gnt<=N; no direct GNT0->GNT1 transition (one idle cycle between owners).
REQ-020 While GNTN: out_adr/we/sel/dat_o = master N inputs; out_cyc_o = mN_cyc_i; out_stb_o = mN_stb_i & (pending != MAXOUT).
REQ-021 While GNTN: mN_stall_o = out_stall_i | (pending == MAXOUT); mN_ack_o = out_ack_i; mN_dat_o = out_dat_i (combinational).
REQ-022 Non-granted master (and both in IDLE): stall_o=1, ack_o=0, dat_o=0.
REQ-023 IDLE: out_cyc_o=out_stb_o=out_we_o=0, out_sel_o=0, out_adr_o=0, out_dat_o=0.
REQ-024 pending: +1 on out_stb_o & !out_stall_i; -1 on out_ack_i with pending>0; both same cycle -> unchanged; never exceeds MAXOUT.
REQ-025 out_ack_i when pending=0 or state IDLE: not forwarded, pending unchanged, spurious_o<=1.
REQ-026 Granted master drops cyc with pending>0 (abort): next state IDLE, pending<=0; later acks handled per REQ-025.
REQ-027 Acks routed only to granted master; never to other master even if it raises cyc.

Reset
REQ-028 rst_i high at edge: state IDLE, last_gnt=1 (master 0 wins first tie), pending=0, spurious_o=0; outputs per REQ-022/023 from next cycle.
REQ-029 Reset mid-transfer: same as REQ-028 regardless of pending or grant; in-flight acks after reset set spurious_o.

Verification
REQ-030 Both m0/m1 cyc+stb rise cycle 1 after reset -> grant_o=01 cycle 2, m1_stall_o=1; m0 drops cyc -> IDLE 1 cycle, then grant_o=10.
REQ-031 m0 burst 6 strobes, out_stall_i=0, no acks -> 4 accepted, pending_o=4, m0_stall_o=1, out_stb_o=0; one ack -> pending_o=3, next strobe accepted.
REQ-032 Simultaneous accept + ack at pending=2 -> pending_o stays 2; out_stall_i=1 with stb -> pending unchanged, m0_stall_o=1.
REQ-033 m1 read adr 0x1000, out_dat_i=0xDEADBEEF with ack -> m1_dat_o=0xDEADBEEF, m1_ack_o=1 same cycle, m0_ack_o=0, m0_dat_o=0.
REQ-034 ack with grant IDLE -> spurious_o=1 and stays 1 until rst_i; m0 aborts at pending=3 -> pending_o=0 next cycle.
REQ-035 rst_i during GNT1 with pending=2 -> next cycle grant_o=00, out_cyc_o=0, pending_o=0; subsequent tie grants m0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-master round-robin arbiter for pipelined Wishbone with an outstanding-strobe limit.
module bus_arbiter_rr #(
    parameter int AWIDTH = 32,
    parameter int MAXOUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWIDTH-1:0] m0_adr_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_dat_i,
    output logic [31:0]       m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_stall_o,
    input  logic [AWIDTH-1:0] m1_adr_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_dat_i,
    output logic [31:0]       m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_stall_o,
    output logic [AWIDTH-1:0] out_adr_o,
    output logic              out_cyc_o,
    output logic              out_stb_o,
    output logic              out_we_o,
    output logic [3:0]        out_sel_o,
    output logic [31:0]       out_dat_o,
    input  logic [31:0]       out_dat_i,
    input  logic              out_ack_i,
    input  logic              out_stall_i,
    output logic [1:0]        grant_o,
    output logic [3:0]        pending_o,
    output logic              spurious_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state, state_nxt;
    logic last_gnt;
    logic sel0, sel1, full, owner_cyc, ack_ok, accept;
    assign sel0 = state == GNT0;
    assign sel1 = state == GNT1;
    assign full = pending_o == 4'(MAXOUT);
    assign owner_cyc = (sel0 & m0_cyc_i) | (sel1 & m1_cyc_i);
    // an ack only counts when it can retire a strobe issued by the current owner
    assign ack_ok = out_ack_i & (sel0 | sel1) & (pending_o != 4'd0);
    assign accept = out_stb_o & ~out_stall_i;
    assign grant_o = {sel1, sel0};
    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (m0_cyc_i && m1_cyc_i) ? (last_gnt ? GNT0 : GNT1) :
                        m0_cyc_i ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
        else if (!owner_cyc)
            state_nxt = IDLE;
    end
    always_comb begin
        out_adr_o  = sel0 ? m0_adr_i : sel1 ? m1_adr_i : '0;
        out_we_o   = sel0 ? m0_we_i  : sel1 ? m1_we_i  : 1'b0;
        out_sel_o  = sel0 ? m0_sel_i : sel1 ? m1_sel_i : 4'd0;
        out_dat_o  = sel0 ? m0_dat_i : sel1 ? m1_dat_i : 32'd0;
        out_cyc_o  = owner_cyc;
        out_stb_o  = ((sel0 & m0_stb_i) | (sel1 & m1_stb_i)) & ~full;
        m0_ack_o   = sel0 & ack_ok;
        m1_ack_o   = sel1 & ack_ok;
        m0_dat_o   = sel0 ? out_dat_i : 32'd0;
        m1_dat_o   = sel1 ? out_dat_i : 32'd0;
        m0_stall_o = ~sel0 | out_stall_i | full;
        m1_stall_o = ~sel1 | out_stall_i | full;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            pending_o  <= 4'd0;
            spurious_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (out_ack_i && !ack_ok)
                spurious_o <= 1'b1;
            // owner leaving with strobes in flight abandons them
            if (state != IDLE && !owner_cyc) begin
                last_gnt  <= sel1;
                pending_o <= 4'd0;
            end else if (accept && !ack_ok)
                pending_o <= pending_o + 4'd1;
            else if (!accept && ack_ok)
                pending_o <= pending_o - 4'd1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: scoreboard bench; a behavioural model predicts every cycle's outputs and a monitor compares.
module tb_bus_arbiter_rr;
    localparam int AW = 32;
    localparam int MO = 4;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;
    logic [AW-1:0] adr [2];
    logic cyc [2], stb [2], we [2];
    logic [3:0] sel [2];
    logic [31:0] wdat [2];
    logic [31:0] out_dat_i = '0;
    logic out_ack_i = 1'b0, out_stall_i = 1'b0;
    logic [31:0] m0_dat_o, m1_dat_o, out_dat_o;
    logic m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
    logic [AW-1:0] out_adr_o;
    logic out_cyc_o, out_stb_o, out_we_o, spurious_o;
    logic [3:0] out_sel_o, pending_o;
    logic [1:0] grant_o;

    bus_arbiter_rr #(.AWIDTH(AW), .MAXOUT(MO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(adr[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
        .m0_sel_i(sel[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_stall_o(m0_stall_o),
        .m1_adr_i(adr[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
        .m1_sel_i(sel[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_stall_o(m1_stall_o),
        .out_adr_o(out_adr_o), .out_cyc_o(out_cyc_o), .out_stb_o(out_stb_o), .out_we_o(out_we_o),
        .out_sel_o(out_sel_o), .out_dat_o(out_dat_o), .out_dat_i(out_dat_i), .out_ack_i(out_ack_i),
        .out_stall_i(out_stall_i), .grant_o(grant_o), .pending_o(pending_o), .spurious_o(spurious_o)
    );

    typedef struct packed {
        logic [1:0]  grant;
        logic [3:0]  pend;
        logic        spur, ocyc, ostb, owe;
        logic [3:0]  osel;
        logic [31:0] oadr, odat;
        logic [1:0]  ack, stall;
        logic [31:0] d0, d1;
    } obs_t;
    obs_t exp_q [$];
    int checks = 0, failures = 0;

    // reference model: who owns the bus, who owned it last, strobes in flight
    int owner = -1, last = 1, pend = 0;
    bit spur = 0;

    function automatic obs_t predict();
        obs_t e = '0;
        bit full = (pend == MO);
        e.pend = 4'(pend);
        e.spur = spur;
        e.stall = 2'b11;
        if (owner >= 0) begin
            e.grant = (owner == 0) ? 2'b01 : 2'b10;
            e.ocyc = cyc[owner];
            e.ostb = stb[owner] && !full;
            e.owe = we[owner];
            e.osel = sel[owner];
            e.oadr = adr[owner];
            e.odat = wdat[owner];
            e.ack[owner] = out_ack_i && pend > 0;
            e.stall[owner] = out_stall_i || full;
            if (owner == 0) e.d0 = out_dat_i; else e.d1 = out_dat_i;
        end
        return e;
    endfunction

    task automatic advance_model();
        bit full = (pend == MO);
        if (rst_i) begin
            owner = -1; last = 1; pend = 0; spur = 0;
            return;
        end
        if (out_ack_i && (owner < 0 || pend == 0)) spur = 1;
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) owner = 1 - last;
            else if (cyc[0]) owner = 0;
            else if (cyc[1]) owner = 1;
        end else if (!cyc[owner]) begin
            last = owner; owner = -1; pend = 0;
        end else begin
            pend += int'(stb[owner] && !full && !out_stall_i) - int'(out_ack_i && pend > 0);
        end
    endtask

    task automatic step(input logic r, c0, s0, c1, s1, a, st, input logic [31:0] rd);
        @(posedge clk);
        advance_model();
        #1;
        rst_i = r; out_ack_i = a; out_stall_i = st; out_dat_i = rd;
        cyc[0] = c0; stb[0] = s0; cyc[1] = c1; stb[1] = s1;
        for (int k = 0; k < 2; k++) begin
            adr[k] = $urandom; we[k] = 1'($urandom); sel[k] = 4'($urandom); wdat[k] = $urandom;
        end
        exp_q.push_back(predict());
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{grant_o, pending_o, spurious_o, out_cyc_o, out_stb_o, out_we_o, out_sel_o,
                  out_adr_o, out_dat_o, {m1_ack_o, m0_ack_o}, {m1_stall_o, m0_stall_o}, m0_dat_o, m1_dat_o};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got=%h want=%h (grant %b/%b pend %0d/%0d spur %b/%b)",
                         $time, a, e, a.grant, e.grant, a.pend, e.pend, a.spur, e.spur);
            end
        end
    end

    initial begin
        logic rc0, rc1;
        for (int k = 0; k < 2; k++) begin
            adr[k] = '0; cyc[k] = 0; stb[k] = 0; we[k] = 0; sel[k] = '0; wdat[k] = '0;
        end
        step(1, 0,0, 0,0, 0,0, 0);
        // both request at once after reset: m0 wins, m1 stalls
        step(0, 1,1, 1,1, 0,0, 0);
        // m0 bursts with no acks until the outstanding limit bites
        repeat (6) step(0, 1,1, 1,1, 0,0, 0);
        step(0, 1,1, 1,1, 1,0, 0);
        step(0, 1,1, 1,1, 0,0, 0);
        step(0, 1,0, 1,1, 1,0, 0);
        step(0, 1,0, 1,1, 1,0, 0);
        step(0, 1,1, 1,1, 1,0, 0);
        step(0, 1,1, 1,1, 0,1, 0);
        step(0, 1,1, 1,1, 0,0, 0);
        // abort with strobes outstanding, then an ack while idle
        step(0, 0,0, 1,1, 0,0, 0);
        step(0, 0,0, 1,0, 1,0, 0);
        // m1 read returning 0xDEADBEEF
        step(0, 0,0, 1,1, 0,0, 0);
        step(0, 1,1, 1,0, 1,0, 32'hDEADBEEF);
        step(0, 1,1, 1,1, 0,0, 0);
        step(0, 1,1, 1,1, 0,0, 0);
        // reset in the middle of m1's grant, then a fresh tie
        step(1, 1,1, 1,1, 0,0, 0);
        step(0, 1,1, 1,1, 1,0, 0);
        step(0, 1,1, 1,1, 0,0, 0);
        step(0, 0,0, 0,0, 0,0, 0);
        rc0 = 0; rc1 = 0;
        repeat (3000) begin
            if ($urandom_range(7) == 0) rc0 = ~rc0;
            if ($urandom_range(7) == 0) rc1 = ~rc1;
            step(($urandom_range(199) == 0), rc0, ($urandom_range(9) < 7), rc1, ($urandom_range(9) < 7),
                 ($urandom_range(99) < 30), ($urandom_range(99) < 25), $urandom);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0 unchecked entries", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
